// File: rtl/ddr_phy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ddr_phy_pkg: shared types and helpers for the DDR2 PHY write path  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ddr_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PRE   = 3'd2,
    ST_BURST = 3'd3,
    ST_POST  = 3'd4
  } wr_state_e;

  localparam int LAT_CNT_W = 4;

  // Tx word layout, MSB first: {rise dq, fall dq, rise be, fall be}
  function automatic int rise_dq_lsb(input int dq_w, input int dm_w);
    return dq_w + 2 * dm_w;
  endfunction

  function automatic int fall_dq_lsb(input int dm_w);
    return 2 * dm_w;
  endfunction

  function automatic int rise_be_lsb(input int dm_w);
    return dm_w;
  endfunction

  function automatic int fall_be_lsb();
    return 0;
  endfunction

  function automatic bit burst_len_ok(input int bl);
    return (bl == 4) || (bl == 8);
  endfunction

  function automatic bit wl_ok(input int wl);
    return (wl >= 2) && (wl <= 15);
  endfunction

  function automatic bit dq_w_ok(input int dq_w, input int dm_w);
    return (dq_w > 0) && (dq_w % 8 == 0) && (dm_w == dq_w / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_wr_lat_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ddr_wr_lat_cnt: loadable saturating down-counter with zero flag    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ddr_wr_lat_cnt #(
  parameter int W = 4
) (
  input  logic         sdram_clk_270,
  input  logic         wb_rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge sdram_clk_270 or posedge wb_rst) begin
    if (wb_rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ddr_wr_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ddr_wr_datapath: DDR2 write latency/DQS timing and registered DQ/DM |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ddr_wr_datapath
  import ddr_phy_pkg::*;
#(
  parameter int DQ_W      = 16,
  parameter int DM_W      = DQ_W / 8,
  parameter int BURST_LEN = 4,
  parameter int WL        = 3
) (
  input  logic                     sdram_clk_270,
  input  logic                     wb_rst,
  input  logic                     wr_start_i,
  input  logic [2*DQ_W+2*DM_W-1:0] tx_dat_i,
  input  logic                     tx_vld_i,
  output logic                     tx_rdy_o,
  input  logic                     dqm_en_i,
  input  logic                     underrun_clr_i,
  output logic [DQ_W-1:0]          dq_rise_o,
  output logic [DQ_W-1:0]          dq_fall_o,
  output logic [DM_W-1:0]          dm_rise_o,
  output logic [DM_W-1:0]          dm_fall_o,
  output logic                     dq_oe_o,
  output logic [DM_W-1:0]          dqs_oe_o,
  output logic                     dqs_tgl_o,
  output logic                     busy_o,
  output logic                     wr_done_o,
  output logic                     underrun_o
);

  localparam int RDQ_LSB = rise_dq_lsb(DQ_W, DM_W);
  localparam int FDQ_LSB = fall_dq_lsb(DM_W);
  localparam int RBE_LSB = rise_be_lsb(DM_W);
  localparam int FBE_LSB = fall_be_lsb();

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD  = LAT_CNT_W'(WL - 2);
  localparam logic [LAT_CNT_W-1:0] BEAT_LOAD = LAT_CNT_W'(BURST_LEN / 2 - 1);

  if (!burst_len_ok(BURST_LEN) || !wl_ok(WL) || !dq_w_ok(DQ_W, DM_W)) begin : g_param_check
    $error("ddr_wr_datapath: illegal DQ_W/DM_W/BURST_LEN/WL");
  end

  wr_state_e state_q, state_d;

  logic                 cnt_load;
  logic [LAT_CNT_W-1:0] cnt_load_val;
  logic                 cnt_dec;
  logic [LAT_CNT_W-1:0] cnt_val;
  logic                 cnt_zero;

  ddr_wr_lat_cnt #(.W(LAT_CNT_W)) u_lat_cnt (
    .sdram_clk_270 (sdram_clk_270),
    .wb_rst        (wb_rst),
    .load_i        (cnt_load),
    .load_val_i    (cnt_load_val),
    .dec_i         (cnt_dec),
    .cnt_o         (cnt_val),
    .zero_o        (cnt_zero)
  );

  always_ff @(posedge sdram_clk_270 or posedge wb_rst) begin
    if (wb_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = LAT_LOAD;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE, ST_POST: begin
        if (wr_start_i) begin
          cnt_load = 1'b1;
          state_d  = (WL == 2) ? ST_PRE : ST_WAIT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        // leave as the count steps to zero so WAIT spans exactly WL-2 clocks
        if (cnt_val == LAT_CNT_W'(1)) state_d = ST_PRE;
      end
      ST_PRE: begin
        cnt_load     = 1'b1;
        cnt_load_val = BEAT_LOAD;
        state_d      = ST_BURST;
      end
      ST_BURST: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_POST;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic in_burst;
  logic dqs_on;
  assign in_burst = (state_q == ST_BURST);
  assign dqs_on   = (state_q == ST_PRE) || in_burst || (state_q == ST_POST);
  assign tx_rdy_o = in_burst;
  assign busy_o   = (state_q != ST_IDLE);

  logic [DQ_W-1:0] dq_rise_q, dq_rise_d, dq_fall_q, dq_fall_d;
  logic [DM_W-1:0] dm_rise_q, dm_rise_d, dm_fall_q, dm_fall_d;
  logic [DM_W-1:0] dqs_oe_q;
  logic            dq_oe_q, dqs_tgl_q, wr_done_q, underrun_q, underrun_d;

  always_comb begin
    dq_rise_d  = '0;
    dq_fall_d  = '0;
    dm_rise_d  = '0;
    dm_fall_d  = '0;
    underrun_d = underrun_q;
    if (underrun_clr_i) underrun_d = 1'b0;
    if (in_burst) begin
      if (tx_vld_i) begin
        dq_rise_d = tx_dat_i[RDQ_LSB +: DQ_W];
        dq_fall_d = tx_dat_i[FDQ_LSB +: DQ_W];
        dm_rise_d = dqm_en_i ? '0 : ~tx_dat_i[RBE_LSB +: DM_W];
        dm_fall_d = dqm_en_i ? '0 : ~tx_dat_i[FBE_LSB +: DM_W];
      end else begin
        // memory timing is fixed: emit a fully masked beat and flag it
        dm_rise_d  = '1;
        dm_fall_d  = '1;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sdram_clk_270 or posedge wb_rst) begin
    if (wb_rst) begin
      dq_rise_q  <= '0;
      dq_fall_q  <= '0;
      dm_rise_q  <= '0;
      dm_fall_q  <= '0;
      dqs_oe_q   <= '0;
      dq_oe_q    <= 1'b0;
      dqs_tgl_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      dq_rise_q  <= dq_rise_d;
      dq_fall_q  <= dq_fall_d;
      dm_rise_q  <= dm_rise_d;
      dm_fall_q  <= dm_fall_d;
      dqs_oe_q   <= {DM_W{dqs_on}};
      dq_oe_q    <= in_burst;
      dqs_tgl_q  <= in_burst;
      wr_done_q  <= (state_q == ST_POST);
      underrun_q <= underrun_d;
    end
  end

  assign dq_rise_o  = dq_rise_q;
  assign dq_fall_o  = dq_fall_q;
  assign dm_rise_o  = dm_rise_q;
  assign dm_fall_o  = dm_fall_q;
  assign dqs_oe_o   = dqs_oe_q;
  assign dq_oe_o    = dq_oe_q;
  assign dqs_tgl_o  = dqs_tgl_q;
  assign wr_done_o  = wr_done_q;
  assign underrun_o = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ddr_wr_datapath: two configurations against a timeline model    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_ddr_wr_datapath;

  localparam int A_DQ = 16, A_DM = 2, A_BL = 4, A_WL = 3;
  localparam int B_DQ = 32, B_DM = 4, B_BL = 8, B_WL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ws = 1'b0, vld = 1'b1, dqm = 1'b0, clr = 1'b0;
  logic [35:0] dat_a = '0;
  logic [71:0] dat_b = '0;

  logic        rdy_a, dqoe_a, tgl_a, busy_a, done_a, und_a;
  logic [15:0] dqr_a, dqf_a;
  logic [1:0]  dmr_a, dmf_a, dqsoe_a;
  logic        rdy_b, dqoe_b, tgl_b, busy_b, done_b, und_b;
  logic [31:0] dqr_b, dqf_b;
  logic [3:0]  dmr_b, dmf_b, dqsoe_b;

  ddr_wr_datapath #(.DQ_W(A_DQ), .DM_W(A_DM), .BURST_LEN(A_BL), .WL(A_WL)) dut_a (
    .sdram_clk_270(clk), .wb_rst(rst), .wr_start_i(ws), .tx_dat_i(dat_a),
    .tx_vld_i(vld), .tx_rdy_o(rdy_a), .dqm_en_i(dqm), .underrun_clr_i(clr),
    .dq_rise_o(dqr_a), .dq_fall_o(dqf_a), .dm_rise_o(dmr_a), .dm_fall_o(dmf_a),
    .dq_oe_o(dqoe_a), .dqs_oe_o(dqsoe_a), .dqs_tgl_o(tgl_a), .busy_o(busy_a),
    .wr_done_o(done_a), .underrun_o(und_a));

  ddr_wr_datapath #(.DQ_W(B_DQ), .DM_W(B_DM), .BURST_LEN(B_BL), .WL(B_WL)) dut_b (
    .sdram_clk_270(clk), .wb_rst(rst), .wr_start_i(ws), .tx_dat_i(dat_b),
    .tx_vld_i(vld), .tx_rdy_o(rdy_b), .dqm_en_i(dqm), .underrun_clr_i(clr),
    .dq_rise_o(dqr_b), .dq_fall_o(dqf_b), .dm_rise_o(dmr_b), .dm_fall_o(dmf_b),
    .dq_oe_o(dqoe_b), .dqs_oe_o(dqsoe_b), .dqs_tgl_o(tgl_b), .busy_o(busy_b),
    .wr_done_o(done_b), .underrun_o(und_b));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each accepted start s fixes every output by its offset k = cycle - s.
  int          s0[2] = '{-1000, -1000};
  int          s1[2] = '{-1000, -1000};
  logic [31:0] p_dqr[2], p_dqf[2];
  logic [3:0]  p_dmr[2], p_dmf[2];
  logic        p_und[2];

  function automatic bit win(input int s, input int c, input int lo, input int hi);
    return (c - s >= lo) && (c - s <= hi);
  endfunction

  task automatic model_cycle(input int d, input int wl, input int h, input int dq, input int dm,
                             input logic [71:0] dat, input logic a_rdy, input logic a_busy,
                             input logic a_dqoe, input logic a_tgl, input logic a_done,
                             input logic a_und, input logic [31:0] a_dqr, input logic [31:0] a_dqf,
                             input logic [3:0] a_dmr, input logic [3:0] a_dmf, input logic [3:0] a_dqsoe);
    logic e_busy, e_rdy, e_on, e_tgl, e_done;
    logic [3:0]  ones, be_r, be_f;
    logic [31:0] m_dq;
    string       pf;
    int          c;
    c    = cyc;
    pf   = (d == 0) ? "a" : "b";
    ones = 4'((1 << dm) - 1);
    m_dq = 32'((64'd1 << dq) - 1);
    if (rst) begin
      s0[d] = -1000; s1[d] = -1000;
      p_dqr[d] = '0; p_dqf[d] = '0; p_dmr[d] = '0; p_dmf[d] = '0; p_und[d] = 1'b0;
    end
    e_busy = win(s0[d], c, 1, wl + h)         || win(s1[d], c, 1, wl + h);
    e_rdy  = win(s0[d], c, wl, wl + h - 1)    || win(s1[d], c, wl, wl + h - 1);
    e_on   = win(s0[d], c, wl, wl + h + 1)    || win(s1[d], c, wl, wl + h + 1);
    e_tgl  = win(s0[d], c, wl + 1, wl + h)    || win(s1[d], c, wl + 1, wl + h);
    e_done = win(s0[d], c, wl + h + 1, wl + h + 1) || win(s1[d], c, wl + h + 1, wl + h + 1);
    chk({pf, ".busy"},   64'(a_busy),  64'(e_busy));
    chk({pf, ".tx_rdy"}, 64'(a_rdy),   64'(e_rdy));
    chk({pf, ".dqs_oe"}, 64'(a_dqsoe), 64'(e_on ? ones : 4'd0));
    chk({pf, ".dq_oe"},  64'(a_dqoe),  64'(e_tgl));
    chk({pf, ".dqs_tgl"},64'(a_tgl),   64'(e_tgl));
    chk({pf, ".wr_done"},64'(a_done),  64'(e_done));
    chk({pf, ".dq_rise"},64'(a_dqr),   64'(p_dqr[d]));
    chk({pf, ".dq_fall"},64'(a_dqf),   64'(p_dqf[d]));
    chk({pf, ".dm_rise"},64'(a_dmr),   64'(p_dmr[d]));
    chk({pf, ".dm_fall"},64'(a_dmf),   64'(p_dmf[d]));
    chk({pf, ".underrun"},64'(a_und),  64'(p_und[d]));
    if (!rst) begin
      if (e_rdy && !vld) p_und[d] = 1'b1;
      else if (clr)      p_und[d] = 1'b0;
      p_dqr[d] = '0; p_dqf[d] = '0; p_dmr[d] = '0; p_dmf[d] = '0;
      if (e_rdy && vld) begin
        p_dqr[d] = 32'(dat >> (dq + 2 * dm)) & m_dq;
        p_dqf[d] = 32'(dat >> (2 * dm)) & m_dq;
        be_r     = 4'(dat >> dm) & ones;
        be_f     = 4'(dat) & ones;
        p_dmr[d] = dqm ? 4'd0 : (~be_r & ones);
        p_dmf[d] = dqm ? 4'd0 : (~be_f & ones);
      end else if (e_rdy) begin
        p_dmr[d] = ones;
        p_dmf[d] = ones;
      end
      if (ws && (c - s0[d] >= wl + h)) begin
        s1[d] = s0[d];
        s0[d] = c;
      end
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, A_WL, A_BL / 2, A_DQ, A_DM, {36'd0, dat_a}, rdy_a, busy_a, dqoe_a, tgl_a,
                done_a, und_a, 32'(dqr_a), 32'(dqf_a), 4'(dmr_a), 4'(dmf_a), 4'(dqsoe_a));
    model_cycle(1, B_WL, B_BL / 2, B_DQ, B_DM, dat_b, rdy_b, busy_b, dqoe_b, tgl_b,
                done_b, und_b, dqr_b, dqf_b, dmr_b, dmf_b, dqsoe_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    repeat (2) tick();
    settle();
    chk("reset busy", 64'(busy_a), 64'd0);
    chk("reset dqs_oe", 64'(dqsoe_b), 64'd0);
    chk("reset underrun", 64'(und_a), 64'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // single burst, words A then B
    ws = 1'b1; tick(); ws = 1'b0; tick(); tick();
    dat_a = {16'h1234, 16'h5678, 4'hF}; settle();
    chk("single rdy t0+3", 64'(rdy_a), 64'd1);
    tick(); dat_a = {16'h9ABC, 16'hDEF0, 4'hF}; settle();
    chk("single rdy t0+4", 64'(rdy_a), 64'd1);
    chk("single A rise", 64'(dqr_a), 64'h1234);
    chk("single A fall", 64'(dqf_a), 64'h5678);
    chk("single dm", 64'({dmr_a, dmf_a}), 64'd0);
    tick(); dat_a = '0; settle();
    chk("single B rise", 64'(dqr_a), 64'h9ABC);
    chk("single B fall", 64'(dqf_a), 64'hDEF0);
    chk("single rdy t0+5", 64'(rdy_a), 64'd0);
    tick(); settle();
    chk("single done t0+6", 64'(done_a), 64'd1);
    repeat (4) tick();

    // byte masking, then the same word with dqm_en
    ws = 1'b1; tick(); ws = 1'b0; tick(); tick();
    dat_a = {16'hAAAA, 16'h5555, 4'b0110}; dqm = 1'b0;
    tick(); dqm = 1'b1; settle();
    chk("mask dm_rise", 64'(dmr_a), 64'b10);
    chk("mask dm_fall", 64'(dmf_a), 64'b01);
    tick(); dqm = 1'b0; dat_a = '0; settle();
    chk("dqm_en dm", 64'({dmr_a, dmf_a}), 64'd0);
    repeat (5) tick();

    // underrun on 3rd beat of an 8-beat burst with WL=2
    dat_b = {32'hCAFE0001, 32'hBEEF0002, 8'hFF};
    ws = 1'b1; tick(); ws = 1'b0; settle();
    chk("wl2 busy t0+1", 64'(busy_b), 64'd1);
    chk("wl2 rdy t0+1", 64'(rdy_b), 64'd0);
    tick(); settle();
    chk("wl2 rdy t0+2", 64'(rdy_b), 64'd1);
    chk("wl2 pre dqs_oe", 64'(dqsoe_b), 64'hF);
    chk("wl2 pre dqs_tgl", 64'(tgl_b), 64'd0);
    tick(); tick(); vld = 1'b0;
    tick(); vld = 1'b1; settle();
    chk("underrun dq", 64'(dqr_b), 64'd0);
    chk("underrun dm", 64'({dmr_b, dmf_b}), 64'hFF);
    chk("underrun flag", 64'(und_b), 64'd1);
    chk("underrun 4th beat", 64'(rdy_b), 64'd1);
    tick(); settle();
    chk("underrun post rdy", 64'(rdy_b), 64'd0);
    tick(); clr = 1'b1; settle();
    chk("underrun done", 64'(done_b), 64'd1);
    tick(); clr = 1'b0; settle();
    chk("underrun cleared", 64'(und_b), 64'd0);
    repeat (4) tick();

    // back-to-back: start in BURST ignored, start in POST accepted
    ws = 1'b1; tick(); ws = 1'b0; tick(); tick();
    ws = 1'b1; tick(); ws = 1'b0; tick();
    ws = 1'b1; settle();
    chk("b2b post busy", 64'(busy_a), 64'd1);
    tick(); ws = 1'b0; settle();
    chk("b2b no idle", 64'(busy_a), 64'd1);
    chk("b2b first done", 64'(done_a), 64'd1);
    tick(); settle();
    chk("b2b pre rdy", 64'(rdy_a), 64'd0);
    tick(); settle();
    chk("b2b burst rdy", 64'(rdy_a), 64'd1);
    chk("b2b pre dqs_oe", 64'({dqsoe_a, tgl_a}), 64'b110);
    tick(); tick(); settle();
    chk("b2b post rdy", 64'(rdy_a), 64'd0);
    repeat (5) tick();

    // reset on the 2nd BURST clock
    ws = 1'b1; tick(); ws = 1'b0; tick(); tick();
    dat_a = {16'h0F0F, 16'hF0F0, 4'hF}; tick();
    rst = 1'b1; #1;
    chk("rst dq", 64'(dqr_a), 64'd0);
    chk("rst enables", 64'({dqoe_a, dqsoe_a, tgl_a}), 64'd0);
    chk("rst busy", 64'(busy_a), 64'd0);
    tick(); rst = 1'b0; tick();
    ws = 1'b1; tick(); ws = 1'b0; tick(); tick(); settle();
    chk("post-rst rdy", 64'(rdy_a), 64'd1);
    tick(); settle();
    chk("post-rst dq", 64'(dqr_a), 64'h0F0F);
    repeat (6) tick();

    for (int i = 0; i < 3000; i++) begin
      ws    = ($urandom_range(0, 5) == 0);
      vld   = ($urandom_range(0, 7) != 0);
      dqm   = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      dat_a = 36'({$urandom(), $urandom()});
      dat_b = {8'($urandom()), $urandom(), $urandom()};
      tick();
    end
    rst = 1'b0; ws = 1'b0;
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_wr_datapath.md
Name: ddr_wr_datapath

Overview:
- Parametrised DDR2 write-side datapath for the versatile_mem_ctrl PHY, running in the sdram_clk_270 domain.
- Accepts write-burst requests from the controller FSM and times the write latency, DQS preamble and postamble.
- Pops Tx FIFO words with a valid/ready handshake and presents registered rise/fall halves of DQ and DM, plus output enables, to the external ddr_ff_out / IO buffer layer.
- Generalises the fixed 16-bit, always-on path to configurable DQ width, burst length and write latency, and adds underrun handling.

Parameters:
DQ_W, 16, DQ pins; must be a multiple of 8
DM_W, DQ_W/8, byte lanes; also the DQS pair count
BURST_LEN, 4, beats per burst; legal values 4 or 8; occupies BURST_LEN/2 clocks
WL, 3, write latency in clocks from wr_start_i to the first data clock; legal range 2..15

Ports:
sdram_clk_270  in  1  data-domain clock
wb_rst  in  1  async reset, active-high
wr_start_i  in  1  one-cycle pulse; WRITE command issued this cycle
tx_dat_i  in  2*DQ_W+2*DM_W  {rise data, fall data, rise byte-enable, fall byte-enable}; MSB first
tx_vld_i  in  1  Tx FIFO word valid
tx_rdy_o  out  1  pop strobe; transfer occurs when tx_vld_i && tx_rdy_o
dqm_en_i  in  1  force all byte enables on (mask ignored)
underrun_clr_i  in  1  clears underrun_o
dq_rise_o  out  DQ_W  DQ for the first half-cycle
dq_fall_o  out  DQ_W  DQ for the second half-cycle
dm_rise_o  out  DM_W  DM pin value for the first half-cycle; 1 = masked
dm_fall_o  out  DM_W  DM pin value for the second half-cycle
dq_oe_o  out  1  DQ/DM output enable
dqs_oe_o  out  DM_W  DQS/DQS_n output enable per lane
dqs_tgl_o  out  1  DQS toggling enable; 0 holds DQS low
busy_o  out  1  FSM not IDLE
wr_done_o  out  1  one-cycle pulse in the last POST cycle
underrun_o  out  1  sticky; a burst beat had no valid data

Behaviour:
- Reset (wb_rst asynchronous, active-high; clock sdram_clk_270):
  - All outputs go to 0, the FSM goes to IDLE and all counters clear.
  - Reset asserted mid-burst aborts immediately; the next cycle after release is IDLE with all enables low.
- FSM states: IDLE, WAIT, PRE, BURST, POST.
- IDLE: on wr_start_i, load lat_cnt = WL-2 and go to WAIT. If WL = 2, go directly to PRE.
- WAIT: decrement lat_cnt each clock. When it reaches 0, go to PRE.
- PRE (1 clock): dqs_oe_o = all ones, dqs_tgl_o = 0, dq_oe_o = 0. Load beat_cnt = BURST_LEN/2-1. Go to BURST.
- BURST (BURST_LEN/2 clocks): dqs_oe_o = all ones, dqs_tgl_o = 1, dq_oe_o = 1, tx_rdy_o = 1.
  - tx_rdy_o is combinational from state, so the FIFO word is consumed in the same clock.
  - Outputs register on the following edge. data_out lags tx_rdy_o by 1 clock, and the enables are registered with matching alignment.
  - When beat_cnt reaches 0, go to POST.
- Byte-enable to DM mapping: dm = ~be. When dqm_en_i = 1, dm = 0 (all bytes written).
- Underrun: a BURST clock with tx_vld_i = 0 drives dq_* = 0 and dm_* = all ones, and sets underrun_o. The burst continues unchanged, because memory timing is fixed.
- POST (1 clock): dqs_oe_o = all ones, dqs_tgl_o = 0, dq_oe_o = 0; wr_done_o = 1.
  - wr_start_i in POST reloads lat_cnt and goes to WAIT (or PRE if WL = 2).
  - Otherwise go to IDLE.
- wr_start_i in WAIT, PRE or BURST is ignored; the controller guarantees tCCD spacing.
- underrun_o: underrun_clr_i clears it. Set takes priority over a simultaneous clear.
- busy_o = (state != IDLE).

Decomposition:
- Package ddr_phy_pkg holds:
  - the state encoding (IDLE=0 .. POST=4);
  - the beat-field offset functions for the tx_dat_i layout;
  - legal-parameter checks for BURST_LEN and WL.
- Sub-module ddr_wr_lat_cnt: a loadable down-counter with a zero flag, reused for WAIT and BURST.

Test Plan:
- Single burst, DQ_W=16, BURST_LEN=4, WL=3. Pulse wr_start_i at t0; FIFO holds words A and B with tx_dat_i[3:0] = 4'hF.
  - tx_rdy_o high at t0+3 and t0+4.
  - dq_rise_o/dq_fall_o = A halves at t0+4 and B halves at t0+5.
  - dm = 0; wr_done_o at t0+6.
- Byte masking: be = 4'b0110 with dqm_en_i = 0 -> dm_rise_o = 2'b10, dm_fall_o = 2'b01. The same word with dqm_en_i = 1 -> both dm outputs = 0.
- Underrun: BURST_LEN=8 with tx_vld_i low on the 3rd beat clock.
  - That clock outputs dq = 0 and dm = 2'b11; underrun_o goes to 1.
  - The burst still lasts 4 clocks; underrun_clr_i then clears underrun_o.
- Back-to-back: wr_start_i during POST -> second PRE occurs WL-1 clocks later with no IDLE cycle between. A wr_start_i during BURST is ignored.
- Reset mid-burst: assert wb_rst on the 2nd BURST clock -> all outputs 0 asynchronously, busy_o = 0. A new wr_start_i after release performs a normal burst.
- Parameter sweep DQ_W=32, WL=2: wr_start_i leads to PRE on the next clock, and dqs_oe_o = 4'hF during PRE/BURST/POST.
